// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding, hazard-event priorities
// and the load-use hazard test.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ISTALL = 2'd1,
        ST_DSTALL = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // Encoded value doubles as priority: larger wins.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_LOAD_USE = 3'd1,
        EV_ICACHE   = 3'd2,
        EV_BRANCH   = 3'd3,
        EV_DCACHE   = 3'd4
    } event_t;

    function automatic logic load_use_hazard(
        input logic       ex_mem_r_en,
        input logic [4:0] ex_regD,
        input logic [4:0] id_regA,
        input logic [4:0] id_regB,
        input logic       id_uses_regB
    );
        return ex_mem_r_en && (ex_regD != 5'd0) &&
               ((ex_regD == id_regA) || (id_uses_regB && (ex_regD == id_regB)));
    endfunction

    function automatic event_t top_event(
        input logic dcache_block,
        input logic branch_taken,
        input logic icache_block,
        input logic load_use
    );
        if (dcache_block)      return EV_DCACHE;
        else if (branch_taken) return EV_BRANCH;
        else if (icache_block) return EV_ICACHE;
        else if (load_use)     return EV_LOAD_USE;
        else                   return EV_NONE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && (count_q != '1))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubble injection and stall/flush
// statistics for a 4-stage in-order pipeline.
//
// state  | meaning
// RUN    | normal flow; load-use or icache miss handled here
// ISTALL | fetch frozen until icache_block drops
// DSTALL | whole pipe frozen on dcache miss; returns to saved state
// FLUSH  | shadow counter running, decode fed bubbles
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int BRANCH_SHADOW = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_regA,
    input  logic [4:0]       id_regB,
    input  logic             id_uses_regB,
    input  logic             ex_mem_r_en,
    input  logic [4:0]       ex_regD,
    input  logic             branch_taken,
    input  logic             icache_block,
    input  logic             dcache_block,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_alu,
    output logic             en_mem,
    output logic             flush_decode,
    output logic             flush_alu,
    output logic             inject_nop,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count
);

    localparam logic [1:0] SHADOW_LOAD = 2'(BRANCH_SHADOW - 1);
    localparam state_t     BR_NEXT     = (BRANCH_SHADOW > 1) ? ST_FLUSH : ST_RUN;

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    logic [1:0] shadow_q, shadow_d;
    logic       flush_inc;
    event_t     ev;

    assign ev = top_event(dcache_block, branch_taken, icache_block,
                          load_use_hazard(ex_mem_r_en, ex_regD, id_regA, id_regB, id_uses_regB));

    always_comb begin
        en_fetch     = 1'b1;
        en_decode    = 1'b1;
        en_alu       = 1'b1;
        en_mem       = 1'b1;
        flush_decode = 1'b0;
        flush_alu    = 1'b0;
        inject_nop   = 1'b0;
        flush_inc    = 1'b0;
        state_d      = state_q;
        saved_d      = saved_q;
        shadow_d     = shadow_q;

        if (reset) begin
            state_d  = ST_RUN;
            saved_d  = ST_RUN;
            shadow_d = 2'd0;
        end else if (ev == EV_DCACHE) begin
            en_fetch  = 1'b0;
            en_decode = 1'b0;
            en_alu    = 1'b0;
            en_mem    = 1'b0;
            state_d   = ST_DSTALL;
            if (state_q != ST_DSTALL)
                saved_d = state_q;
        end else if (ev == EV_BRANCH) begin
            flush_decode = 1'b1;
            flush_alu    = 1'b1;
            flush_inc    = 1'b1;
            shadow_d     = SHADOW_LOAD;
            state_d      = BR_NEXT;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ev == EV_ICACHE || ev == EV_LOAD_USE) begin
                        en_fetch     = 1'b0;
                        en_decode    = 1'b0;
                        flush_decode = 1'b1;
                        inject_nop   = 1'b1;
                    end
                    if (ev == EV_ICACHE)
                        state_d = ST_ISTALL;
                end
                ST_ISTALL: begin
                    en_fetch     = 1'b0;
                    en_decode    = 1'b0;
                    flush_decode = 1'b1;
                    inject_nop   = 1'b1;
                    state_d      = icache_block ? ST_ISTALL : ST_RUN;
                end
                ST_FLUSH: begin
                    flush_decode = 1'b1;
                    if (shadow_q <= 2'd1) begin
                        shadow_d = 2'd0;
                        state_d  = icache_block ? ST_ISTALL : ST_RUN;
                    end else begin
                        shadow_d = shadow_q - 2'd1;
                    end
                end
                ST_DSTALL: begin
                    // Exit cycle runs with default outputs; the saved state picks up next cycle.
                    state_d = saved_q;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        saved_q  <= saved_d;
        shadow_q <= shadow_d;
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (~en_fetch),
        .count (stall_cycles)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .en    (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised + directed bench for pipeline_hazard_ctrl, checked against an
// in-bench behavioural model every cycle.
module tb_pipeline_hazard_ctrl;

    localparam int BS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_regA, id_regB, ex_regD;
    logic       id_uses_regB, ex_mem_r_en, branch_taken, icache_block, dcache_block;

    logic        en_fetch, en_decode, en_alu, en_mem, flush_decode, flush_alu, inject_nop;
    logic [1:0]  state;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    logic        en_fetch4, en_decode4, en_alu4, en_mem4, flush_decode4, flush_alu4, inject_nop4;
    logic [1:0]  state4;
    logic [3:0]  stall_cycles4;
    logic [15:0] flush_count4;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.BRANCH_SHADOW(BS), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_regA(id_regA), .id_regB(id_regB),
        .id_uses_regB(id_uses_regB), .ex_mem_r_en(ex_mem_r_en), .ex_regD(ex_regD),
        .branch_taken(branch_taken), .icache_block(icache_block), .dcache_block(dcache_block),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_alu(en_alu), .en_mem(en_mem),
        .flush_decode(flush_decode), .flush_alu(flush_alu), .inject_nop(inject_nop),
        .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.BRANCH_SHADOW(BS), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_regA(id_regA), .id_regB(id_regB),
        .id_uses_regB(id_uses_regB), .ex_mem_r_en(ex_mem_r_en), .ex_regD(ex_regD),
        .branch_taken(branch_taken), .icache_block(icache_block), .dcache_block(dcache_block),
        .en_fetch(en_fetch4), .en_decode(en_decode4), .en_alu(en_alu4), .en_mem(en_mem4),
        .flush_decode(flush_decode4), .flush_alu(flush_alu4), .inject_nop(inject_nop4),
        .state(state4), .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural model: 0 run, 1 icache wait, 2 dcache wait, 3 flushing
    int     m_mode = 0, m_resume = 0, m_left = 0;
    longint m_stall = 0;
    int     m_stall4 = 0, m_flush = 0;
    bit     chk_en = 1'b0;

    always @(negedge clk) begin
        bit       lu, fd, fa, nop;
        bit [3:0] en;
        if (chk_en) begin
            lu = ex_mem_r_en && ex_regD != 0 &&
                 (ex_regD == id_regA || (id_uses_regB && ex_regD == id_regB));
            en = 4'b1111; fd = 0; fa = 0; nop = 0;
            if (reset) begin
            end else if (dcache_block) begin
                en = 4'b0000;
            end else if (branch_taken) begin
                fd = 1; fa = 1;
            end else if (m_mode == 3) begin
                fd = 1;
            end else if (m_mode == 1 || (m_mode == 0 && (icache_block || lu))) begin
                en = 4'b0011; fd = 1; nop = 1;
            end

            chk("enables", {en_fetch, en_decode, en_alu, en_mem}, en);
            chk("flush_decode", flush_decode, fd);
            chk("flush_alu", flush_alu, fa);
            chk("inject_nop", inject_nop, nop);
            chk("state", state, m_mode);
            chk("stall_cycles", stall_cycles, m_stall);
            chk("flush_count", flush_count, m_flush);
            chk("enables_w4", {en_fetch4, en_decode4, en_alu4, en_mem4, flush_decode4, flush_alu4, inject_nop4},
                {en, fd, fa, nop});
            chk("state_w4", state4, m_mode);
            chk("stall_cycles_w4", stall_cycles4, m_stall4);
            chk("flush_count_w4", flush_count4, m_flush);

            if (reset) begin
                m_mode = 0; m_resume = 0; m_left = 0;
                m_stall = 0; m_stall4 = 0; m_flush = 0;
            end else begin
                if (!en[3]) begin
                    if (m_stall < 64'hFFFF_FFFF) m_stall++;
                    if (m_stall4 < 15) m_stall4++;
                end
                if (dcache_block) begin
                    if (m_mode != 2) m_resume = m_mode;
                    m_mode = 2;
                end else if (branch_taken) begin
                    if (m_flush < 65535) m_flush++;
                    m_left = BS - 1;
                    m_mode = (m_left > 0) ? 3 : 0;
                end else begin
                    case (m_mode)
                        0: m_mode = icache_block ? 1 : 0;
                        1: m_mode = icache_block ? 1 : 0;
                        2: m_mode = m_resume;
                        default: begin
                            m_left--;
                            if (m_left <= 0) begin
                                m_left = 0;
                                m_mode = icache_block ? 1 : 0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic drive(input bit r, input bit dc, input bit br, input bit ic,
                         input bit mre, input int rd, input int ra, input int rb, input bit ub);
        reset = r; dcache_block = dc; branch_taken = br; icache_block = ic;
        ex_mem_r_en = mre; ex_regD = 5'(rd); id_regA = 5'(ra); id_regB = 5'(rb); id_uses_regB = ub;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_en = 1'b1;
        #1;
        chk("reset_enables", {en_fetch, en_decode, en_alu, en_mem, flush_decode, flush_alu, inject_nop}, 7'b1111000);
        chk("reset_state", state, 0);
        cyc();

        // load-use stall for exactly one cycle
        drive(0, 0, 0, 0, 1, 5, 5, 0, 0);
        #1;
        chk("lu_stall", {en_fetch, en_decode, flush_decode, inject_nop}, 4'b0011);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lu_count", stall_cycles, 1);
        chk("lu_release", en_fetch, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
        #1;
        chk("lu_r0_nostall", en_fetch, 1);
        cyc();

        // taken branch, shadow of two
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("br_cycle1", {flush_decode, flush_alu, en_fetch}, 3'b111);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("br_cycle2", {state, flush_decode, flush_alu}, {2'd3, 2'b10});
        cyc();
        chk("br_cycle3", {state, flush_decode}, {2'd0, 1'b0});
        chk("br_count", flush_count, 1);

        // dcache miss held four cycles during FLUSH
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dc_frozen", {en_fetch, en_decode, en_alu, en_mem, flush_decode}, 5'b00000);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("dc_exit", {state, en_fetch}, {2'd2, 1'b1});
        cyc();
        chk("dc_flush_resume", {state, flush_decode}, {2'd3, 1'b1});
        cyc();
        chk("dc_run", state, 0);
        chk("dc_stall_count", stall_cycles, 5);

        // icache miss and branch together
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("ib_branch_wins", {flush_decode, flush_alu, en_fetch}, 3'b111);
        cyc();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("ib_flush", state, 3);
        cyc();
        chk("ib_istall", {state, en_fetch, inject_nop}, {2'd1, 2'b01});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ib_fall", state, 1);
        cyc();
        chk("ib_run", {state, en_fetch}, {2'd0, 1'b1});
        chk("ib_flush_count", flush_count, 3);

        // reset mid-ISTALL
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("rst_pre", state, 1);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_outputs", {en_fetch, en_decode, en_alu, en_mem, flush_decode, flush_alu, inject_nop}, 7'b1111000);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_after", {state, en_fetch, en_decode, en_alu, en_mem}, {2'd0, 4'b1111});
        chk("rst_counters", {stall_cycles, flush_count}, 48'd0);

        // 20 stall cycles: 4-bit counter saturates
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (20) cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_w32", stall_cycles, 20);
        chk("sat_w4", stall_cycles4, 15);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1);
            cyc();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
